// File: rtl/rs232_avs_responder_pkg.sv
// Shared definitions for the RS232 Avalon-MM responder.
// Holds the register map byte addresses, STATUS bit positions and the
// state encodings for the transmit and receive serial engines.
package rs232_pkg;

  // Register map (byte addresses on the 5-bit Avalon address bus)
  localparam logic [4:0] RX_BASE     = 5'd0;
  localparam logic [4:0] TX_BASE     = 5'd4;
  localparam logic [4:0] STATUS_BASE = 5'd8;

  // STATUS register bit positions
  localparam int RX_OK_BIT     = 7;
  localparam int TX_OK_BIT     = 6;
  localparam int FRAME_ERR_BIT = 2;
  localparam int TX_DROP_BIT   = 1;
  localparam int RX_OVR_BIT    = 0;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_START = 2'd1,
    T_DATA  = 2'd2,
    T_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/rs232_avs_responder_if.sv
// Avalon-MM bus bundle between the wrapper (master) and the RS232
// responder (slave).
//   avs_address     byte address (0 RX, 4 TX, 8 STATUS)
//   avs_read        read request
//   avs_write       write request
//   avs_writedata   write data, bits [7:0] meaningful
//   avs_readdata    read data, valid while avs_waitrequest is low
//   avs_waitrequest stall
//
// Handshake: the master raises avs_read or avs_write together with
// avs_address/avs_writedata and holds all of them unchanged while
// avs_waitrequest is high. The transfer completes in the first cycle with
// avs_waitrequest low; avs_readdata is valid in exactly that cycle and the
// master may drop or change the request after the following clock edge.
interface rs232_avs_responder_if;
  logic [4:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/rs232_avs_responder_byte_fifo.sv
// Small synchronous byte FIFO with show-ahead output.
//   clk, rst_n  clock, asynchronous active-low reset
//   push, din   write a byte (ignored when full unless a pop frees a slot)
//   pop         discard the head byte (ignored when empty)
//   dout        current head byte (undefined when empty)
//   empty, full occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic [7:0]  mem_q [DEPTH];
  logic        do_pop;
  logic        do_push;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop in the same cycle frees the head slot, so a push to a full FIFO
  // is still accepted and occupancy stays unchanged.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/rs232_avs_responder.sv
// RS232 UART register-map responder on an Avalon-MM slave port.
//   avs_clk, avs_rst_n  clock, asynchronous active-low reset
//   avs                 Avalon-MM slave bus (address/read/write/writedata,
//                       readdata/waitrequest)
//   uart_rxd            serial input, idles high, 8N1
//   uart_txd            serial output, idles high, 8N1
//   dbg_tx_state        current transmit engine state
//   dbg_rx_state        current receive engine state
// Bytes written to TX are queued and serialised; bytes received on the line
// are queued for RX reads. STATUS reports queue state and sticky error flags.
module rs232_avs_responder
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 avs_clk,
  input  logic                 avs_rst_n,
  rs232_avs_responder_if.slave avs,
  input  logic                 uart_rxd,
  output logic                 uart_txd,
  output tx_state_e            dbg_tx_state,
  output rx_state_e            dbg_rx_state
);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  // ---------------- FIFOs ----------------
  logic       tx_push, tx_pop, tx_empty, tx_full;
  logic       rx_push, rx_pop, rx_empty, rx_full;
  logic [7:0] tx_dout, rx_dout, rx_shreg_q;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(avs_clk), .rst_n(avs_rst_n), .push(tx_push), .pop(tx_pop),
    .din(avs.avs_writedata[7:0]), .dout(tx_dout), .empty(tx_empty), .full(tx_full)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(avs_clk), .rst_n(avs_rst_n), .push(rx_push), .pop(rx_pop),
    .din(rx_shreg_q), .dout(rx_dout), .empty(rx_empty), .full(rx_full)
  );

  logic unused_wdata;
  assign unused_wdata = ^avs.avs_writedata[31:8];

  // ---------------- Bus side ----------------
  logic        ack_q;
  logic [31:0] rdata_q, rdata_d, status_word;
  logic        rx_pop_armed_q;
  logic        req, capture, rd_acc, wr_acc, status_rd;
  logic [2:0]  flags_q, flag_set, flag_clr;

  assign req     = avs.avs_read | avs.avs_write;
  assign capture = req & ~ack_q;            // the wait cycle
  assign rd_acc  = ack_q & avs.avs_read;    // read wins over write
  assign wr_acc  = ack_q & avs.avs_write & ~avs.avs_read;

  assign avs.avs_waitrequest = ~ack_q;
  assign avs.avs_readdata    = rdata_q;

  assign tx_push   = wr_acc & (avs.avs_address == TX_BASE);
  // Pop only if the wait-cycle snapshot actually returned a byte, so a byte
  // arriving into an empty FIFO during the wait cycle is not lost.
  assign rx_pop    = rd_acc & (avs.avs_address == RX_BASE) & rx_pop_armed_q;
  assign status_rd = rd_acc & (avs.avs_address == STATUS_BASE);

  always_comb begin
    status_word                = '0;
    status_word[RX_OK_BIT]     = ~rx_empty;
    status_word[TX_OK_BIT]     = ~tx_full;
    status_word[FRAME_ERR_BIT] = flags_q[FRAME_ERR_BIT];
    status_word[TX_DROP_BIT]   = flags_q[TX_DROP_BIT];
    status_word[RX_OVR_BIT]    = flags_q[RX_OVR_BIT];
  end

  always_comb begin
    rdata_d = '0;
    if (avs.avs_read) begin
      case (avs.avs_address)
        RX_BASE:     rdata_d = rx_empty ? 32'd0 : {24'd0, rx_dout};
        STATUS_BASE: rdata_d = status_word;
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge avs_clk or negedge avs_rst_n) begin
    if (!avs_rst_n) begin
      ack_q          <= 1'b0;
      rdata_q        <= '0;
      rx_pop_armed_q <= 1'b0;
    end else begin
      ack_q          <= capture;
      rdata_q        <= capture ? rdata_d : '0;
      rx_pop_armed_q <= capture & avs.avs_read &
                        (avs.avs_address == RX_BASE) & ~rx_empty;
    end
  end

  // ---------------- Sticky flags ----------------
  logic rx_frame_ev;

  always_comb begin
    flag_set                = '0;
    flag_set[FRAME_ERR_BIT] = rx_frame_ev;
    flag_set[TX_DROP_BIT]   = tx_push & tx_full & ~tx_pop;
    flag_set[RX_OVR_BIT]    = rx_push & rx_full & ~rx_pop;
  end

  // Clear only the flags the STATUS read reported; a flag raised after the
  // snapshot, or in the accept cycle itself, survives.
  assign flag_clr = status_rd ? rdata_q[2:0] : 3'b000;

  always_ff @(posedge avs_clk or negedge avs_rst_n) begin
    if (!avs_rst_n) flags_q <= '0;
    else            flags_q <= (flags_q & ~flag_clr) | flag_set;
  end

  // ---------------- Transmit engine ----------------
  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_shreg_q, tx_shreg_d;
  logic          txd_q, txd_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shreg_d = tx_shreg_q;
    tx_pop     = 1'b0;
    txd_d      = 1'b1;
    case (tx_state_q)
      T_IDLE: if (!tx_empty) begin
        tx_pop     = 1'b1;
        tx_shreg_d = tx_dout;
        tx_cnt_d   = '0;
        tx_state_d = T_START;
      end
      T_START: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_idx_d   = '0;
        tx_state_d = T_DATA;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      T_DATA: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        if (tx_idx_q == 3'd7) tx_state_d = T_STOP;
        else                  tx_idx_d   = tx_idx_q + 3'd1;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      T_STOP: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_state_d = T_IDLE;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      default: tx_state_d = T_IDLE;
    endcase
    // Line level is registered from the next state to keep uart_txd glitch-free.
    case (tx_state_d)
      T_START: txd_d = 1'b0;
      T_DATA:  txd_d = tx_shreg_d[tx_idx_d];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge avs_clk or negedge avs_rst_n) begin
    if (!avs_rst_n) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shreg_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shreg_q <= tx_shreg_d;
      txd_q      <= txd_d;
    end
  end

  assign uart_txd     = txd_q;
  assign dbg_tx_state = tx_state_q;

  // ---------------- Receive engine ----------------
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_shreg_d;
  logic          rxd_s1_q, rxd_s2_q;

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_idx_d    = rx_idx_q;
    rx_shreg_d  = rx_shreg_q;
    rx_push     = 1'b0;
    rx_frame_ev = 1'b0;
    case (rx_state_q)
      R_IDLE: if (!rxd_s2_q) begin
        rx_cnt_d   = '0;
        rx_state_d = R_START;
      end
      // Re-check the start bit near its centre; a high line means a glitch.
      R_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_idx_d   = '0;
        rx_state_d = rxd_s2_q ? R_IDLE : R_DATA;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      R_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d             = '0;
        rx_shreg_d[rx_idx_q] = rxd_s2_q;
        if (rx_idx_q == 3'd7) rx_state_d = R_STOP;
        else                  rx_idx_d   = rx_idx_q + 3'd1;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      // Leave straight after the stop sample so the next start edge is caught.
      R_STOP: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d    = '0;
        rx_push     = rxd_s2_q;
        rx_frame_ev = ~rxd_s2_q;
        rx_state_d  = R_IDLE;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge avs_clk or negedge avs_rst_n) begin
    if (!avs_rst_n) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shreg_q <= '0;
    end else begin
      rxd_s1_q   <= uart_rxd;
      rxd_s2_q   <= rxd_s1_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shreg_q <= rx_shreg_d;
    end
  end

  assign dbg_rx_state = rx_state_q;
endmodule

// File: tb/tb_rs232_avs_responder.sv
module tb_rs232_avs_responder;
  import rs232_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic      clk;
  logic      rst_n;
  logic      rxd;
  logic      txd;
  tx_state_e dbg_tx;
  rx_state_e dbg_rx;

  rs232_avs_responder_if bus ();

  rs232_avs_responder #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .avs_clk(clk), .avs_rst_n(rst_n), .avs(bus),
    .uart_rxd(rxd), .uart_txd(txd),
    .dbg_tx_state(dbg_tx), .dbg_rx_state(dbg_rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];      // bytes the RX FIFO should hold, head first
  logic       m_fe, m_drop, m_ovr, m_tx_full;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    m_fe = 0; m_drop = 0; m_ovr = 0; m_tx_full = 0;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok)                 m_fe = 1;
    else if (exp_q.size() >= DEPTH) m_ovr = 1;
    else                          exp_q.push_back(b);
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = '0;
    s[RX_OK_BIT]     = (exp_q.size() != 0);
    s[TX_OK_BIT]     = ~m_tx_full;
    s[FRAME_ERR_BIT] = m_fe;
    s[TX_DROP_BIT]   = m_drop;
    s[RX_OVR_BIT]    = m_ovr;
    return s;
  endfunction

  // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
  task automatic bus_xfer(input logic rd, input logic wr, input logic [4:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata);
    int lat;
    lat = 0;
    bus.avs_address = addr; bus.avs_read = rd; bus.avs_write = wr; bus.avs_writedata = wdata;
    while (bus.avs_waitrequest !== 1'b0 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    rdata = bus.avs_readdata;
    check("handshake_latency", 32'(lat), 32'd1);
    @(negedge clk);
    bus.avs_read = 0; bus.avs_write = 0; bus.avs_address = '0; bus.avs_writedata = '0;
  endtask

  task automatic bus_write(input logic [4:0] addr, input logic [31:0] wdata);
    logic [31:0] dummy;
    bus_xfer(1'b0, 1'b1, addr, wdata, dummy);
  endtask

  task automatic status_check(input string name);
    logic [31:0] r;
    bus_xfer(1'b1, 1'b0, STATUS_BASE, '0, r);
    check(name, r, model_status());
    m_fe = 0; m_drop = 0; m_ovr = 0;
  endtask

  task automatic rx_check(input string name);
    logic [31:0] r, e;
    bus_xfer(1'b1, 1'b0, RX_BASE, '0, r);
    e = (exp_q.size() != 0) ? {24'd0, exp_q.pop_front()} : 32'd0;
    check(name, r, e);
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = frame[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for a start bit on uart_txd; returns at the first low sample.
  task automatic wait_tx_start(input string name);
    int w;
    w = 0;
    while (txd !== 1'b0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check(name, {31'd0, txd}, 32'd0);
  endtask

  // Line-level UART receiver: sample each bit at its centre.
  task automatic tx_capture(output logic [7:0] b);
    wait_tx_start("tx_start_found");
    repeat (CPB / 2) @(negedge clk);
    check("tx_start_mid", {31'd0, txd}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = txd;
    end
    repeat (CPB) @(negedge clk);
    check("tx_stop_bit", {31'd0, txd}, 32'd1);
    repeat (CPB) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_txd_async", {31'd0, txd}, 32'd1);
    repeat (3) @(negedge clk);
    check("rst_waitrequest", {31'd0, bus.avs_waitrequest}, 32'd1);
    check("rst_readdata", bus.avs_readdata, 32'd0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // ---------------- table-driven register-map vectors ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] r;
    logic [7:0]  b;
    logic [7:0]  pat_byte;
    logic [9:0]  pat;
    int          low_seen;

    rst_n = 1'b0; rxd = 1'b1;
    bus.avs_address = '0; bus.avs_read = 0; bus.avs_write = 0; bus.avs_writedata = '0;
    model_reset();

    vecs[0] = '{1, 0, STATUS_BASE, 32'h0,  32'h40, "status_after_reset"};
    vecs[1] = '{1, 0, RX_BASE,     32'h0,  32'h00, "rx_read_empty"};
    vecs[2] = '{1, 0, TX_BASE,     32'h0,  32'h00, "tx_read_zero"};
    vecs[3] = '{1, 0, 5'h0C,       32'h0,  32'h00, "unmapped_0c_read"};
    vecs[4] = '{1, 0, 5'h1F,       32'h0,  32'h00, "unmapped_1f_read"};
    vecs[5] = '{0, 1, RX_BASE,     32'h55, 32'h00, "wr_rx_ignored"};
    vecs[6] = '{0, 1, STATUS_BASE, 32'hFF, 32'h00, "wr_status_ignored"};
    vecs[7] = '{0, 1, 5'h10,       32'h12, 32'h00, "wr_unmapped_ignored"};
    vecs[8] = '{1, 1, TX_BASE,     32'h77, 32'h00, "rd_wr_tx_is_read"};
    vecs[9] = '{1, 0, STATUS_BASE, 32'h0,  32'h40, "status_after_table"};

    idle(2);
    check("rst_waitrequest_early", {31'd0, bus.avs_waitrequest}, 32'd1);
    check("rst_readdata_early", bus.avs_readdata, 32'd0);
    check("rst_txd_early", {31'd0, txd}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_tx_idle", 32'(dbg_tx), 32'(T_IDLE));
    check("rst_rx_idle", 32'(dbg_rx), 32'(R_IDLE));

    // Test 1 and register-map basics
    for (int i = 0; i < 10; i++) begin
      bus_xfer(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, r);
      if (vecs[i].rd) check(vecs[i].name, r, vecs[i].exp);
    end
    low_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) low_seen++;
    end
    check("no_tx_from_ignored_writes", 32'(low_seen), 32'd0);

    // Test 2: exact TX waveform for 0xA5
    pat_byte = 8'hA5;
    pat = {1'b1, pat_byte, 1'b0};
    bus_write(TX_BASE, {24'd0, pat_byte});
    wait_tx_start("tx_a5_start");
    for (int i = 0; i < 40; i++) begin
      if (i != 0) @(negedge clk);
      check($sformatf("tx_a5_cycle%0d", i), {31'd0, txd}, {31'd0, pat[i / CPB]});
    end
    low_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) low_seen++;
    end
    check("tx_a5_idle_after", 32'(low_seen), 32'd0);

    // Test 3: one received byte
    uart_send(8'h3C, 1'b1); model_frame(8'h3C, 1'b1); idle(4);
    status_check("rx_3c_status");
    rx_check("rx_3c_data");
    status_check("rx_3c_status_after");

    // Test 4: overrun with 5 back-to-back frames
    for (int i = 1; i <= 5; i++) begin
      uart_send(8'(i), 1'b1);
      model_frame(8'(i), 1'b1);
    end
    idle(4);
    status_check("ovr_status");
    for (int i = 0; i < 4; i++) rx_check($sformatf("ovr_rx%0d", i));
    status_check("ovr_status_cleared");

    // Test 5: framing error
    uart_send(8'h5A, 1'b0); model_frame(8'h5A, 1'b0); idle(4);
    status_check("frame_err_status");
    status_check("frame_err_cleared");

    // Randomised mix of RX frames, RX/STATUS reads and TX bytes
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: begin
          b = 8'($urandom_range(0, 255));
          pat_byte = ($urandom_range(0, 7) != 0) ? 8'd1 : 8'd0;
          uart_send(b, pat_byte[0]); model_frame(b, pat_byte[0]); idle(4);
        end
        3: rx_check("rand_rx");
        4: status_check("rand_status");
        default: begin
          pat_byte = 8'($urandom_range(0, 255));
          bus_write(TX_BASE, {24'd0, pat_byte});
          tx_capture(b);
          check("rand_tx_byte", {24'd0, b}, {24'd0, pat_byte});
        end
      endcase
    end
    while (exp_q.size() != 0) rx_check("rand_drain_rx");
    status_check("rand_final_status");

    // Test 6: TX overflow then reset mid-frame
    for (int i = 0; i < 6; i++) bus_write(TX_BASE, 32'(i * 17));  // first byte 0x00
    m_tx_full = 1; m_drop = 1;
    check("tx_in_flight_line_low", {31'd0, txd}, 32'd0);
    status_check("tx_drop_status");
    idle(3);
    do_reset();
    status_check("post_reset_status");
    low_seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) low_seen++;
    end
    check("post_reset_txd_idle", 32'(low_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
